// File: rtl/fifo_seq_checker.sv
// fifo_seq_checker: single-clock read-side consumer for fifo_sram.
// Drains NUM_WORDS words and checks them against an incrementing sequence.
module fifo_seq_checker #(
  parameter int WIDTH     = 8,
  parameter int NUM_WORDS = 10,
  parameter int START_VAL = 1,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             rd_empty,
  input  logic             rd_val,
  input  logic [WIDTH-1:0] rd_data,
  output logic             rd_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [CNT_W-1:0] rcv_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] L_NUM   = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] L_ONE_C = CNT_W'(1);
  localparam logic [TMO_W-1:0] L_TMAX  = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] L_ONE_T = TMO_W'(1);
  localparam logic [WIDTH-1:0] L_START = WIDTH'(START_VAL);
  localparam logic [WIDTH-1:0] L_ONE_W = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_iss_cnt;
  logic [CNT_W-1:0] r_rcv_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_first_idx;
  logic [WIDTH-1:0] r_exp;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_timeout;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_iss_nxt;
  logic [CNT_W-1:0] w_rcv_nxt;
  logic [CNT_W-1:0] w_err_nxt;
  logic [CNT_W-1:0] w_first_nxt;
  logic [WIDTH-1:0] w_exp_nxt;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_pass_nxt;
  logic             w_timeout_nxt;

  logic             w_rd_en;
  logic             w_run;
  logic             w_acc;
  logic             w_mis;
  logic [CNT_W-1:0] w_err_inc;

  assign w_run   = (r_state == S_DRAIN) | (r_state == S_FLUSH);
  assign w_rd_en = (r_state == S_DRAIN) & ~rd_empty
                 & (r_iss_cnt < L_NUM);
  assign w_acc   = rd_val & w_run & (r_rcv_cnt < L_NUM);
  assign w_mis   = w_acc & (rd_data != r_exp);

  // err_cnt sticks at all-ones instead of wrapping
  assign w_err_inc = (r_err_cnt == '1) ? r_err_cnt
                                       : r_err_cnt + L_ONE_C;

  always_comb begin
    w_state_nxt   = r_state;
    w_iss_nxt     = r_iss_cnt;
    w_rcv_nxt     = r_rcv_cnt;
    w_err_nxt     = r_err_cnt;
    w_first_nxt   = r_first_idx;
    w_exp_nxt     = r_exp;
    w_tmo_nxt     = r_tmo_cnt;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_pass_nxt    = r_pass;
    w_timeout_nxt = r_timeout;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt   = S_DRAIN;
          w_iss_nxt     = '0;
          w_rcv_nxt     = '0;
          w_err_nxt     = '0;
          w_first_nxt   = '1;
          w_exp_nxt     = L_START;
          w_tmo_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_done_nxt    = 1'b0;
          w_pass_nxt    = 1'b0;
          w_timeout_nxt = 1'b0;
        end else if (rd_val) begin
          w_err_nxt = w_err_inc;
          if (r_done) w_pass_nxt = 1'b0;
        end
      end
      S_DRAIN, S_FLUSH: begin
        if (w_rd_en) w_iss_nxt = r_iss_cnt + L_ONE_C;
        if (w_acc) begin
          w_rcv_nxt = r_rcv_cnt + L_ONE_C;
          w_exp_nxt = r_exp + L_ONE_W;
          if (w_mis) begin
            w_err_nxt = w_err_inc;
            if (r_first_idx == '1) w_first_nxt = r_rcv_cnt;
          end
        end else if (rd_val) begin
          w_err_nxt = w_err_inc;
        end
        if (rd_val) begin
          w_tmo_nxt = '0;
        end else if (r_tmo_cnt != L_TMAX) begin
          w_tmo_nxt = r_tmo_cnt + L_ONE_T;
        end
        // a word arriving on the threshold cycle wins over timeout
        if (!rd_val && (r_tmo_cnt == L_TMAX)) begin
          w_state_nxt   = S_DONE;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_pass_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
        end else if (r_state == S_DRAIN) begin
          if (w_iss_nxt == L_NUM) w_state_nxt = S_FLUSH;
        end else if (w_rcv_nxt == L_NUM) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_nxt == '0) & ~r_timeout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_iss_cnt   <= '0;
      r_rcv_cnt   <= '0;
      r_err_cnt   <= '0;
      r_first_idx <= '1;
      r_exp       <= L_START;
      r_tmo_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_iss_cnt   <= w_iss_nxt;
      r_rcv_cnt   <= w_rcv_nxt;
      r_err_cnt   <= w_err_nxt;
      r_first_idx <= w_first_nxt;
      r_exp       <= w_exp_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign rd_en         = w_rd_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign err_cnt       = r_err_cnt;
  assign first_err_idx = r_first_idx;
  assign rcv_cnt       = r_rcv_cnt;

endmodule

// File: doc/fifo_seq_checker.md
Name: fifo_seq_checker

Overview:
- Synthesizable read-side consumer for fifo_sram in single-clock mode (SYNCH=1). After a start pulse it drains exactly NUM_WORDS entries from the FIFO.
- Each returned word is checked against an incrementing expected sequence. The block reports error count, first-mismatch index, timeout and pass/done status.
- It is the reader counterpart to the incrementing-data writer used for fifo_sram bring-up, and is reused in on-chip loopback self-test.

Parameters:
- WIDTH, 8, FIFO entry width; must match fifo_sram WIDTH.
- NUM_WORDS, 10, number of words to read and check per run (>=1).
- START_VAL, 1, expected value of the first word.
- TIMEOUT, 64, max consecutive cycles with reads outstanding or pending and no rd_val before aborting (>=2).
- CNT_W, $clog2(NUM_WORDS+1), width of the word and error counters (derived; do not override).

Ports:
- clk  in  1  single clock; drives fifo_sram wr_clk/rd_clk.
- rstb  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- rd_empty  in  1  fifo_sram rd_empty.
- rd_val  in  1  fifo_sram rd_val; qualifies rd_data.
- rd_data  in  WIDTH  fifo_sram rd_data.
- rd_en  out  1  fifo_sram rd_en.
- busy  out  1  run in progress (DRAIN or FLUSH).
- done  out  1  run finished; held until next start.
- pass  out  1  valid when done=1: err_cnt==0 and no timeout.
- timeout  out  1  sticky: run aborted by the TIMEOUT counter.
- err_cnt  out  CNT_W  mismatches plus spurious rd_val count; saturates at all-ones.
- first_err_idx  out  CNT_W  word index (0-based) of first mismatch; all-ones if none.
- rcv_cnt  out  CNT_W  words received this run.

Behaviour:
- Reset (rstb=0, async): state=IDLE. rd_en=0, busy=0, done=0, pass=0, timeout=0, err_cnt=0, first_err_idx=all-ones, rcv_cnt=0. Internal iss_cnt=0, exp=START_VAL, tmo_cnt=0.
- Reset mid-run aborts immediately with no completion report. Words already in flight from the FIFO are lost.
- States: IDLE, DRAIN, FLUSH, DONE. All state and outputs are registered except rd_en.
- rd_en is combinational: (state==DRAIN) & ~rd_empty & (iss_cnt<NUM_WORDS). It is never asserted when rd_empty=1.
- Read latency: a word read with rd_en in cycle N returns with rd_val=1 in cycle N+1. Back-to-back rd_en gives back-to-back rd_val.
- IDLE/DONE + start=1:
  - clear err_cnt, rcv_cnt, iss_cnt, tmo_cnt and timeout;
  - set exp=START_VAL and first_err_idx=all-ones;
  - set done=0 and pass=0;
  - go to DRAIN, with busy=1 the next cycle.
- start in DRAIN or FLUSH is ignored.
- DRAIN:
  - iss_cnt increments on each cycle where rd_en=1.
  - When iss_cnt reaches NUM_WORDS (including the cycle it gets there), go to FLUSH.
- rd_val=1 while rcv_cnt<NUM_WORDS and state is DRAIN or FLUSH:
  - compare rd_data with exp;
  - increment rcv_cnt;
  - set exp=exp+1, modulo 2^WIDTH (all-ones wraps to 0).
  - On mismatch: err_cnt+1 (saturating). If first_err_idx is all-ones, load it with the current rcv_cnt.
- FLUSH: when rcv_cnt reaches NUM_WORDS, go to DONE. Set done=1, busy=0, pass=(err_cnt==0)&~timeout, using the updated err_cnt.
- Spurious rd_val: rd_val=1 in IDLE or DONE, or when rcv_cnt==NUM_WORDS, increments err_cnt (saturating). It does not change rcv_cnt or exp.
  - A spurious rd_val while done=1 also clears pass.
- Timeout:
  - In DRAIN or FLUSH, tmo_cnt increments on every cycle with rd_val=0 and resets to 0 on rd_val=1.
  - An empty FIFO in DRAIN therefore also counts.
  - When tmo_cnt reaches TIMEOUT-1 with rd_val=0: go to DONE with timeout=1, pass=0, done=1. rcv_cnt keeps the partial count.
- Simultaneous events: the rd_val that completes the last word and the timeout threshold in the same cycle resolve as completion, because rd_val=1 resets tmo_cnt.
- The counters never wrap past NUM_WORDS. err_cnt holds at all-ones.

Test Plan:
- Write 1..10 into fifo_sram (DEPTH=8; excess writes dropped while full), start, drain concurrently with writes → 10 rd_en pulses, rcv_cnt=10, err_cnt=0, pass=1, done held.
- Preload 8 words 1,2,3,9,5,6,7,8, NUM_WORDS=8 → err_cnt=1, first_err_idx=3, pass=0, done=1, no timeout.
- WIDTH=8, START_VAL=250, feed 250..255,0..3 (NUM_WORDS=10) → wraparound accepted, err_cnt=0, pass=1.
- Only 4 words available, TIMEOUT=16 → rd_en stops after 4 reads, timeout=1 about 16 cycles later, rcv_cnt=4, pass=0, done=1.
- Inject rd_val in IDLE, and a start pulse during DRAIN → err_cnt=1 at next run's... cleared by start; start during DRAIN ignored, run completes normally with iss_cnt=NUM_WORDS.
- Assert rstb low mid-DRAIN after 3 words, release, start again with a refilled FIFO → all outputs at reset values, new run passes with rcv_cnt=NUM_WORDS.
